// File: rtl/reset_sequencer.sv
// Board reset sequencer: staggered release of CPU/PCIe/BCM/1G resets after
// platform reset, plus the front-panel reset-button hold timer.
`ifndef PwrSW_On
`define PwrSW_On 1'b1
`endif

module reset_sequencer #(
    parameter int unsigned STAGE_DLY = 8,
    parameter int unsigned BTN_HOLD  = 131072,
    parameter int unsigned RST_PULSE = 33,
    parameter int unsigned CNT_W     = 18
) (
    input  logic       MCLKi,
    input  logic       RESETi,
    input  logic       Tick32K,
    input  logic       PLTRST_N,
    input  logic       FM_PS_EN,
    input  logic       RstBtn_N,
    output logic [3:0] RstStage_N,
    output logic       SeqDone,
    output logic [1:0] SeqState,
    output logic       ResetOut_ox
);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } seq_t;

    typedef enum logic [1:0] {
        B_ARM     = 2'd0,
        B_PULSE   = 2'd1,
        B_HOLDOFF = 2'd2
    } btn_t;

    localparam logic [7:0]       DLY_LAST   = 8'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(BTN_HOLD - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0] plt_ff;
    logic [1:0] pwr_ff;
    logic [1:0] btn_ff;
    logic       plt_sync;
    logic       power_ok;
    logic       btn_sync;
    logic       run_ok;

    seq_t       seq_q, seq_d;
    logic [7:0] dly_q, dly_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] stage_q, stage_d;
    logic       done_q, done_d;

    btn_t             bst_q, bst_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic             rout_q, rout_d;

    always_ff @(posedge MCLKi) begin
        if (RESETi) begin
            plt_ff <= 2'b00;
            pwr_ff <= 2'b00;
            btn_ff <= 2'b11;
        end else begin
            plt_ff <= {plt_ff[0], PLTRST_N};
            pwr_ff <= {pwr_ff[0], FM_PS_EN};
            btn_ff <= {btn_ff[0], RstBtn_N};
        end
    end

    assign plt_sync = plt_ff[1];
    assign btn_sync = btn_ff[1];
    assign power_ok = (pwr_ff[1] == `PwrSW_On);
    assign run_ok   = plt_sync && power_ok;

    always_ff @(posedge MCLKi) begin
        if (RESETi) begin
            seq_q   <= S_WAIT;
            dly_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            bst_q   <= B_ARM;
            hold_q  <= '0;
            pulse_q <= '0;
            rout_q  <= 1'b1;
        end else begin
            seq_q   <= seq_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            bst_q   <= bst_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            rout_q  <= rout_d;
        end
    end

    // Abort is checked ahead of the case so it beats a same-cycle release tick.
    always_comb begin
        seq_d   = seq_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        if (seq_q != S_WAIT && !run_ok) begin
            seq_d   = S_WAIT;
            dly_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
        end else begin
            unique case (seq_q)
                S_WAIT: begin
                    stage_d = '0;
                    done_d  = 1'b0;
                    if (run_ok) begin
                        seq_d = S_RELEASE;
                        dly_d = '0;
                        idx_d = '0;
                    end
                end
                S_RELEASE: begin
                    if (Tick32K) begin
                        if (dly_q == DLY_LAST) begin
                            stage_d[idx_q] = 1'b1;
                            dly_d          = '0;
                            idx_d          = idx_q + 2'd1;
                            if (idx_q == 2'd3) begin
                                seq_d  = S_DONE;
                                done_d = 1'b1;
                            end
                        end else begin
                            dly_d = dly_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    stage_d = 4'b1111;
                    done_d  = 1'b1;
                end
                default: begin
                    seq_d   = S_WAIT;
                    stage_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bst_d   = bst_q;
        hold_d  = hold_q;
        pulse_d = pulse_q;
        rout_d  = rout_q;
        if (!power_ok) begin
            bst_d   = B_ARM;
            hold_d  = '0;
            pulse_d = '0;
            rout_d  = 1'b1;
        end else begin
            unique case (bst_q)
                B_ARM: begin
                    rout_d = 1'b1;
                    if (btn_sync) begin
                        hold_d = '0;
                    end else if (Tick32K) begin
                        if (hold_q == HOLD_LAST) begin
                            bst_d   = B_PULSE;
                            hold_d  = '0;
                            pulse_d = '0;
                            rout_d  = 1'b0;
                        end else if (hold_q != CNT_MAX) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                B_PULSE: begin
                    if (Tick32K) begin
                        if (pulse_q == PULSE_LAST) begin
                            bst_d  = B_HOLDOFF;
                            rout_d = 1'b1;
                        end else begin
                            pulse_d = pulse_q + 1'b1;
                        end
                    end
                end
                B_HOLDOFF: begin
                    // One pulse per press: re-arm only after release.
                    rout_d = 1'b1;
                    if (btn_sync) begin
                        bst_d  = B_ARM;
                        hold_d = '0;
                    end
                end
                default: begin
                    bst_d  = B_ARM;
                    rout_d = 1'b1;
                end
            endcase
        end
    end

    assign RstStage_N  = stage_q;
    assign SeqDone     = done_q;
    assign SeqState    = seq_q;
    assign ResetOut_ox = rout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGE_DLY=2, BTN_HOLD=4,
// RST_PULSE=3 and a 32K tick every 4 clocks.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       plt_n;
    logic       ps_en;
    logic       btn_n;
    logic       tick_gen;
    logic       tick_man;
    logic       tick;
    logic [3:0] stage;
    logic       done;
    logic [1:0] state;
    logic       rout;

    int errors = 0;
    int checks = 0;
    int ticks_done = 0;
    int ph = 0;
    bit tick_auto = 1'b0;

    assign tick = tick_gen | tick_man;

    always #5 clk = ~clk;

    reset_sequencer #(
        .STAGE_DLY(2),
        .BTN_HOLD(4),
        .RST_PULSE(3),
        .CNT_W(18)
    ) dut (
        .MCLKi(clk),
        .RESETi(rst),
        .Tick32K(tick),
        .PLTRST_N(plt_n),
        .FM_PS_EN(ps_en),
        .RstBtn_N(btn_n),
        .RstStage_N(stage),
        .SeqDone(done),
        .SeqState(state),
        .ResetOut_ox(rout)
    );

    // Counts ticks consumed by the DUT and generates the periodic tick.
    initial begin
        tick_gen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick) ticks_done++;
            ph = (ph + 1) % 4;
            tick_gen = tick_auto && (ph == 3);
        end
    end

    task automatic pulse_tick();
        @(negedge clk);
        tick_man = 1'b1;
        @(negedge clk);
        tick_man = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        plt_n = 1'b0;
        ps_en = 1'b0;
        btn_n = 1'b1;
        tick_auto = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (stage !== 4'b0000) $display("FAIL reset_stage: got %b expected 0000", stage);
        if (stage !== 4'b0000) errors++;
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL reset_done: got %b expected 0", done);
            errors++;
        end
        checks++;
        if (state !== 2'd0) begin
            $display("FAIL reset_state: got %0d expected 0", state);
            errors++;
        end
        checks++;
        if (rout !== 1'b1) begin
            $display("FAIL reset_rout: got %b expected 1", rout);
            errors++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (stage !== 4'b0000 || state !== 2'd0) begin
            $display("FAIL idle_wait: got stage %b state %0d expected 0000/0", stage, state);
            errors++;
        end
    endtask

    task automatic test_power_up();
        int n;
        int t0;
        logic [3:0] prev;
        logic [3:0] exp_stage;
        ps_en = 1'b1;
        repeat (3) @(negedge clk);
        plt_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state !== 2'd1 && n < 20);
        checks++;
        if (n != 3 || state !== 2'd1) begin
            $display("FAIL release_latency: got %0d edges state %0d expected 3 edges state 1", n, state);
            errors++;
        end
        t0 = ticks_done;
        exp_stage = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            prev = stage;
            exp_stage = {exp_stage[2:0], 1'b1};
            n = 0;
            while (stage === prev && n < 100) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (stage !== exp_stage) begin
                $display("FAIL pu_stage%0d: got %b expected %b", k, stage, exp_stage);
                errors++;
            end
            checks++;
            if (ticks_done - t0 != 2 * (k + 1)) begin
                $display("FAIL pu_tick%0d: got %0d expected %0d", k, ticks_done - t0, 2 * (k + 1));
                errors++;
            end
            checks++;
            if (done !== (k == 3)) begin
                $display("FAIL pu_done%0d: got %b expected %b", k, done, (k == 3));
                errors++;
            end
        end
        checks++;
        if (state !== 2'd2) begin
            $display("FAIL pu_state_done: got %0d expected 2", state);
            errors++;
        end
    endtask

    task automatic test_abort();
        int n;
        int t0;
        plt_n = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stage !== 4'b0000 && n < 10);
        checks++;
        if (n > 3 || stage !== 4'b0000 || state !== 2'd0 || done !== 1'b0) begin
            $display("FAIL abort_done: got %0d edges stage %b state %0d done %b expected <=3/0000/0/0",
                     n, stage, state, done);
            errors++;
        end
        plt_n = 1'b1;
        n = 0;
        while (stage !== 4'b0011 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (stage !== 4'b0011) begin
            $display("FAIL abort_reach_0011: got %b expected 0011", stage);
            errors++;
        end
        plt_n = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stage !== 4'b0000 && n < 10);
        checks++;
        if (n > 3 || stage !== 4'b0000) begin
            $display("FAIL abort_mid_latency: got %0d edges stage %b expected <=3/0000", n, stage);
            errors++;
        end
        checks++;
        if (done !== 1'b0 || state !== 2'd0) begin
            $display("FAIL abort_mid_state: got done %b state %0d expected 0/0", done, state);
            errors++;
        end
        plt_n = 1'b1;
        n = 0;
        while (state !== 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t0 = ticks_done;
        n = 0;
        while (stage === 4'b0000 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (stage !== 4'b0001 || ticks_done - t0 != 2) begin
            $display("FAIL restart_stage0: got %b after %0d ticks expected 0001 after 2",
                     stage, ticks_done - t0);
            errors++;
        end
    endtask

    task automatic test_simul_abort();
        int n;
        tick_auto = 1'b0;
        repeat (2) @(negedge clk);
        plt_n = 1'b0;
        repeat (4) @(negedge clk);
        plt_n = 1'b1;
        n = 0;
        while (state !== 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (4) pulse_tick();
        checks++;
        if (stage !== 4'b0011) begin
            $display("FAIL simul_pre: got %b expected 0011", stage);
            errors++;
        end
        pulse_tick();
        // The stage-2 tick lands on the edge where the synced low is first seen.
        plt_n = 1'b0;
        @(negedge clk);
        checks++;
        if (stage[2] !== 1'b0) begin
            $display("FAIL simul_e1: got %b expected bit2 0", stage);
            errors++;
        end
        @(negedge clk);
        tick_man = 1'b1;
        @(negedge clk);
        tick_man = 1'b0;
        checks++;
        if (stage !== 4'b0000 || state !== 2'd0) begin
            $display("FAIL simul_abort: got %b state %0d expected 0000 state 0", stage, state);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (stage !== 4'b0000) begin
            $display("FAIL simul_after: got %b expected 0000", stage);
            errors++;
        end
    endtask

    task automatic test_button_long();
        logic exp_r;
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int t = 1; t <= 10; t++) begin
            pulse_tick();
            exp_r = (t >= 4 && t <= 6) ? 1'b0 : 1'b1;
            checks++;
            if (rout !== exp_r) begin
                $display("FAIL long_tick%0d: got %b expected %b", t, rout, exp_r);
                errors++;
            end
        end
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        repeat (2) pulse_tick();
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) pulse_tick();
        checks++;
        if (rout !== 1'b1) begin
            $display("FAIL repress_early: got %b expected 1", rout);
            errors++;
        end
        pulse_tick();
        checks++;
        if (rout !== 1'b0) begin
            $display("FAIL repress_pulse: got %b expected 0", rout);
            errors++;
        end
        repeat (3) pulse_tick();
        checks++;
        if (rout !== 1'b1) begin
            $display("FAIL repress_end: got %b expected 1", rout);
            errors++;
        end
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_short_press();
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) pulse_tick();
        checks++;
        if (rout !== 1'b1) begin
            $display("FAIL short_first: got %b expected 1", rout);
            errors++;
        end
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse_tick();
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (3) pulse_tick();
        checks++;
        if (rout !== 1'b1) begin
            $display("FAIL glitch_no_pulse: got %b expected 1", rout);
            errors++;
        end
        pulse_tick();
        checks++;
        if (rout !== 1'b0) begin
            $display("FAIL glitch_fourth: got %b expected 0", rout);
            errors++;
        end
        repeat (3) pulse_tick();
        btn_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_power_loss();
        int n;
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) pulse_tick();
        checks++;
        if (rout !== 1'b0) begin
            $display("FAIL pwr_pulse_on: got %b expected 0", rout);
            errors++;
        end
        ps_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rout !== 1'b1 && n < 10);
        checks++;
        if (n > 3 || rout !== 1'b1) begin
            $display("FAIL pwr_pulse_cut: got %0d edges rout %b expected <=3/1", n, rout);
            errors++;
        end
        btn_n = 1'b1;
        ps_en = 1'b1;
        repeat (3) @(negedge clk);
        pulse_tick();
        checks++;
        if (rout !== 1'b1) begin
            $display("FAIL pwr_restore_idle: got %b expected 1", rout);
            errors++;
        end
        plt_n = 1'b1;
        tick_auto = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== 2'd2 || stage !== 4'b1111) begin
            $display("FAIL pwr_reach_done: got state %0d stage %b expected 2/1111", state, stage);
            errors++;
        end
        ps_en = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stage !== 4'b0000 && n < 10);
        checks++;
        if (n > 3 || stage !== 4'b0000 || done !== 1'b0 || state !== 2'd0) begin
            $display("FAIL pwr_done_abort: got %0d edges stage %b done %b state %0d expected <=3/0000/0/0",
                     n, stage, done, state);
            errors++;
        end
        ps_en = 1'b1;
        n = 0;
        while (stage !== 4'b0011 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (stage !== 4'b0011) begin
            $display("FAIL rst_reach_0011: got %b expected 0011", stage);
            errors++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (stage !== 4'b0000 || done !== 1'b0 || state !== 2'd0 || rout !== 1'b1) begin
            $display("FAIL rst_mid: got stage %b done %b state %0d rout %b expected 0000/0/0/1",
                     stage, done, state, rout);
            errors++;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tick_man = 1'b0;
        rst = 1'b1;
        plt_n = 1'b0;
        ps_en = 1'b0;
        btn_n = 1'b1;
        test_reset();
        test_power_up();
        test_abort();
        test_simul_abort();
        test_button_long();
        test_short_press();
        test_power_loss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
